// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the data-memory path: SRAM controller FSM states
// and bus/word sizes used by Mem_Stage and the top-level freeze logic.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int WORD_W  = 32;
    localparam int WORD_AW = SRAM_AW - 1;   // 32-bit word index; the LSB of sram_addr selects the half
    localparam int COUNT_W = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-access wait counter for the SRAM controller: counts the cycles one 16-bit
// access is held on the bus and flags the final one.
module sram_wait_counter
    import mips_mem_pkg::*;
#(
    parameter int SRAM_WAIT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    output logic [COUNT_W-1:0] count_next,
    output logic               last
);

    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(SRAM_WAIT - 1);

    logic [COUNT_W-1:0] count;

    // Clear wins over enable so a half finishing on its last count restarts at zero.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            count_next = count + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign last = (count == LAST_COUNT);

endmodule

// File: rtl/mem_sram_ctrl.sv
// Data-memory controller: splits a 32-bit load/store into two timed 16-bit
// accesses (low half first) on an asynchronous SRAM, freezing the pipeline meanwhile.
module mem_sram_ctrl
    import mips_mem_pkg::*;
#(
    parameter int SRAM_WAIT = 3,
    parameter int ADDR_BASE = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_r_en,
    input  logic                mem_w_en,
    input  logic [WORD_W-1:0]   address,
    input  logic [WORD_W-1:0]   st_val,
    output logic [WORD_W-1:0]   read_data,
    output logic                ready,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [SRAM_DW-1:0]  sram_dq_out,
    input  logic [SRAM_DW-1:0]  sram_dq_in,
    output logic                sram_dq_oe,
    output logic                sram_we_n,
    output sram_state_t         state
);

    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(SRAM_WAIT - 1);
    localparam logic [WORD_W-1:0]  BASE       = WORD_W'(ADDR_BASE);

    // Handshake: a request (mem_r_en | mem_w_en) is held stable by the pipeline
    // while ready=0; ready=1 either with no request pending or in the single DONE
    // cycle, and the pipeline advances on the edge that ends that cycle.

    sram_state_t        state_next;
    logic               req;
    logic               last;
    logic [COUNT_W-1:0] count_next;
    logic               count_clear;

    logic               op_store_q;
    logic               op_load_q;
    logic [WORD_AW-1:0] word_q;
    logic [WORD_W-1:0]  data_q;

    logic               op_store;
    logic [WORD_AW-1:0] op_word;
    logic [WORD_W-1:0]  op_data;
    logic [WORD_W-1:0]  offset;
    logic               unused_offset_bits;

    logic [SRAM_AW-1:0] addr_d;
    logic [SRAM_DW-1:0] dq_out_d;
    logic               oe_d;
    logic               we_n_d;
    logic               half_d;

    assign req   = mem_r_en | mem_w_en;
    assign ready = ~req | (state == DONE);

    assign offset             = address - BASE;
    assign unused_offset_bits = ^{offset[WORD_W-1:WORD_AW+2], offset[1:0]};

    // The operation is captured when it starts so a request that drops mid-access still completes.
    assign op_store = (state == IDLE) ? mem_w_en                  : op_store_q;
    assign op_word  = (state == IDLE) ? offset[WORD_AW+1:2]       : word_q;
    assign op_data  = (state == IDLE) ? st_val                    : data_q;

    assign count_clear = (state == IDLE) || (state == DONE) || last;

    sram_wait_counter #(
        .SRAM_WAIT (SRAM_WAIT)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (count_clear),
        .enable     (1'b1),
        .count_next (count_next),
        .last       (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req)  state_next = LOW;
            LOW:     if (last) state_next = HIGH;
            HIGH:    if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus values are decoded from the next state/count and registered, so the
    // SRAM pins change only on clock edges and line up with the state they belong to.
    always_comb begin
        addr_d   = '0;
        dq_out_d = '0;
        oe_d     = 1'b0;
        we_n_d   = 1'b1;
        half_d   = (state_next == HIGH);
        if ((state_next == LOW) || (state_next == HIGH)) begin
            addr_d = {op_word, half_d};
            if (op_store) begin
                oe_d     = 1'b1;
                dq_out_d = half_d ? op_data[WORD_W-1:SRAM_DW] : op_data[SRAM_DW-1:0];
                we_n_d   = (count_next == LAST_COUNT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            sram_addr   <= addr_d;
            sram_dq_out <= dq_out_d;
            sram_dq_oe  <= oe_d;
            sram_we_n   <= we_n_d;
        end
    end

    // A simultaneous read+write request is treated as a store only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_store_q <= 1'b0;
            op_load_q  <= 1'b0;
            word_q     <= '0;
            data_q     <= '0;
        end else if ((state == IDLE) && req) begin
            op_store_q <= mem_w_en;
            op_load_q  <= mem_r_en & ~mem_w_en;
            word_q     <= offset[WORD_AW+1:2];
            data_q     <= st_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= '0;
        end else if (op_load_q && last) begin
            if (state == LOW) begin
                read_data[SRAM_DW-1:0] <= sram_dq_in;
            end else if (state == HIGH) begin
                read_data[WORD_W-1:SRAM_DW] <= sram_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Testbench for mem_sram_ctrl: SRAM behavioural model, per-cycle bus checks and
// a read_data scoreboard popped when ready rises.
module tb_mem_sram_ctrl;
    import mips_mem_pkg::*;

    localparam int W = 3;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] st_val;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    sram_state_t state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_model;
    logic [31:0] word_model[0:3];
    logic [15:0] sram_mem[0:262143];

    mem_sram_ctrl #(
        .SRAM_WAIT (W),
        .ADDR_BASE (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .address     (address),
        .st_val      (st_val),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .state       (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // SRAM model: preload and writes live in one process
    assign sram_dq_in = sram_mem[sram_addr];

    initial begin
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
        sram_mem[4] = 16'h1234;
        sram_mem[5] = 16'h5678;
        forever begin
            @(negedge clk);
            if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] = sram_dq_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        address  = 32'd0;
        st_val   = 32'd0;
    endtask

    // Driver: called just after a rising edge; returns just after the edge ending DONE.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] exp_rd);
        logic [31:0] offs;
        logic [16:0] word;
        logic        half;
        int          c;
        int          cyc;
        bit          done;
        mem_r_en = rd;
        mem_w_en = wr;
        address  = addr;
        st_val   = data;
        exp_q.push_back(exp_rd);
        offs = addr - 32'd1024;
        word = offs[18:2];
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc <= 4 * W + 4) begin
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
                check("latency", 32'(cyc), 32'(2 * W + 1));
                check("done_state", 32'(state), 32'(DONE));
                check("done_oe", 32'(sram_dq_oe), 32'd0);
                check("done_we_n", 32'(sram_we_n), 32'd1);
                if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
                else check("read_data", read_data, exp_q.pop_front());
            end else if (cyc >= 1 && cyc <= 2 * W) begin
                half = ((cyc - 1) / W) == 1;
                c    = (cyc - 1) % W;
                check("sram_addr", 32'(sram_addr), 32'({word, half}));
                check("oe", 32'(sram_dq_oe), 32'(wr));
                if (wr) begin
                    check("dq_out", 32'(sram_dq_out), half ? 32'(data[31:16]) : 32'(data[15:0]));
                    check("we_n", 32'(sram_we_n), 32'(c == W - 1));
                end else begin
                    check("we_n", 32'(sram_we_n), 32'd1);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) check("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic        rd;
        logic [1:0]  k;
        logic [31:0] data;
        rst = 1'b1;
        rd_model = 32'd0;
        idle_inputs();
        #1 rst = 1'b0;
        #2;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // reset in the middle of the high half of a store
        @(posedge clk); #1;
        mem_w_en = 1'b1; address = 32'd1028; st_val = 32'hDEAD_BEEF;
        repeat (5) @(posedge clk);
        #1;
        check("mid_high_state", 32'(state), 32'(HIGH));
        #1;
        rst = 1'b0;
        idle_inputs();
        #1;
        check("mid_rst_state", 32'(state), 32'(IDLE));
        check("mid_rst_we_n", 32'(sram_we_n), 32'd1);
        check("mid_rst_oe", 32'(sram_dq_oe), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_read_data", read_data, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // store
        run_access(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, rd_model);
        idle_inputs();
        check("mem_2", 32'(sram_mem[2]), 32'h0000_BEEF);
        check("mem_3", 32'(sram_mem[3]), 32'h0000_DEAD);

        // load
        run_access(1'b1, 1'b0, 32'd1032, 32'd0, 32'h5678_1234);
        rd_model = 32'h5678_1234;
        idle_inputs();

        // back-to-back store then load of the same word
        run_access(1'b0, 1'b1, 32'd1024, 32'hCAFE_F00D, rd_model);
        run_access(1'b1, 1'b0, 32'd1024, 32'd0, 32'hCAFE_F00D);
        rd_model = 32'hCAFE_F00D;
        idle_inputs();

        // no request
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_we_n", 32'(sram_we_n), 32'd1);
            check("idle_state", 32'(state), 32'(IDLE));
            @(posedge clk); #1;
        end

        // read+write together at a wrapping address
        run_access(1'b1, 1'b1, 32'd1020, 32'hA5A5_5A5A, rd_model);
        idle_inputs();
        check("wrap_mem_lo", 32'(sram_mem[18'h3FFFE]), 32'h0000_5A5A);
        check("wrap_mem_hi", 32'(sram_mem[18'h3FFFF]), 32'h0000_A5A5);
        run_access(1'b1, 1'b0, 32'd1020, 32'd0, 32'hA5A5_5A5A);
        rd_model = 32'hA5A5_5A5A;
        idle_inputs();

        // random traffic over four words
        word_model[0] = 32'hCAFE_F00D;
        word_model[1] = 32'hDEAD_BEEF;
        word_model[2] = 32'h5678_1234;
        word_model[3] = 32'h0000_0000;
        for (int n = 0; n < 12; n++) begin
            rd   = 1'($urandom_range(0, 1));
            k    = 2'($urandom_range(0, 3));
            data = $urandom;
            if (rd) begin
                rd_model = word_model[k];
                run_access(1'b1, 1'b0, 32'd1024 + 32'(k) * 32'd4, 32'd0, rd_model);
            end else begin
                word_model[k] = data;
                run_access(1'b0, 1'b1, 32'd1024 + 32'(k) * 32'd4, data, rd_model);
            end
            idle_inputs();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
